// File: rtl/addr_ctr_stack_if.sv
// Control/data bundle for addr_ctr_stack: the datapath drives the controls and D_IN,
// and the address register drives the address, stack status and flags.
interface addr_ctr_stack_if #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic             CLR;
    logic             LD;
    logic             INC;
    logic             DEC;
    logic             PUSH;
    logic             POP;
    logic [WIDTH-1:0] D_IN;
    logic [WIDTH-1:0] D_OUT;
    logic [WIDTH-1:0] TOP;
    logic [LW-1:0]    LEVEL;
    logic             FULL;
    logic             EMPTY;
    logic             BOUND;
    logic             ERR;

    modport master (
        output CLR, LD, INC, DEC, PUSH, POP, D_IN,
        input  D_OUT, TOP, LEVEL, FULL, EMPTY, BOUND, ERR
    );

    modport slave (
        input  CLR, LD, INC, DEC, PUSH, POP, D_IN,
        output D_OUT, TOP, LEVEL, FULL, EMPTY, BOUND, ERR
    );
endinterface

// File: rtl/addr_ctr_stack.sv
// Address register with clear/load/inc/dec and a DEPTH-entry return stack.
// Define ADDR_SAT_EN to saturate at the address boundaries instead of wrapping.
module addr_ctr_stack #(
    parameter int  WIDTH = 12,
    parameter int  DEPTH = 4,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input logic            CLK,
    input logic            reset,
    addr_ctr_stack_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] d_out_q;
    logic [LW-1:0]    level_q;
    logic             bound_q;
    logic             err_q;
    logic [WIDTH-1:0] stack_q [DEPTH];

    logic             full;
    logic             empty;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    top_idx;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign wr_idx  = IW'(level_q);
    assign top_idx = IW'(level_q - LW'(1));

    // The whole datapath updates on the falling edge of the clock.
    always_ff @(negedge CLK) begin
        if (reset) begin
            d_out_q <= '0;
            level_q <= '0;
            bound_q <= 1'b0;
            err_q   <= 1'b0;
            // NOTE: the stack must read back as zeros after reset, so every entry is cleared here
            // rather than left to power-up values; this rules out a plain RAM macro for it.
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
            bound_q <= 1'b0;
            if (bus.CLR) begin
                d_out_q <= '0;
                err_q   <= 1'b0;
            end else if (bus.POP) begin
                if (empty) begin
                    err_q <= 1'b1;
                end else begin
                    d_out_q <= stack_q[top_idx];
                    level_q <= level_q - LW'(1);
                end
            end else if (bus.PUSH) begin
                if (full) begin
                    err_q <= 1'b1;
                end else begin
                    stack_q[wr_idx] <= d_out_q + WIDTH'(1);
                    level_q         <= level_q + LW'(1);
                    d_out_q         <= bus.D_IN;
                end
            end else if (bus.LD) begin
                d_out_q <= bus.D_IN;
            end else if (bus.INC) begin
                if (d_out_q == '1) begin
                    bound_q <= 1'b1;
`ifdef ADDR_SAT_EN
                    d_out_q <= d_out_q;
`else
                    d_out_q <= '0;
`endif
                end else begin
                    d_out_q <= d_out_q + WIDTH'(1);
                end
            end else if (bus.DEC) begin
                if (d_out_q == '0) begin
                    bound_q <= 1'b1;
`ifdef ADDR_SAT_EN
                    d_out_q <= d_out_q;
`else
                    d_out_q <= '1;
`endif
                end else begin
                    d_out_q <= d_out_q - WIDTH'(1);
                end
            end
        end
    end

    assign bus.D_OUT = d_out_q;
    assign bus.LEVEL = level_q;
    assign bus.FULL  = full;
    assign bus.EMPTY = empty;
    assign bus.BOUND = bound_q;
    assign bus.ERR   = err_q;
    assign bus.TOP   = empty ? '0 : stack_q[top_idx];
endmodule

// File: tb/tb_addr_ctr_stack.sv
// Directed bench for addr_ctr_stack (WIDTH=12, DEPTH=4); expected values are hand-computed.
module tb_addr_ctr_stack;
    localparam int WIDTH = 12;
    localparam int DEPTH = 4;

    // Control masks: {CLR, LD, INC, DEC, PUSH, POP}
    localparam logic [5:0] NOP  = 6'b000000;
    localparam logic [5:0] CLR  = 6'b100000;
    localparam logic [5:0] LD   = 6'b010000;
    localparam logic [5:0] INC  = 6'b001000;
    localparam logic [5:0] DEC  = 6'b000100;
    localparam logic [5:0] PUSH = 6'b000010;
    localparam logic [5:0] POP  = 6'b000001;

`ifdef ADDR_SAT_EN
    localparam logic [11:0] INC_EDGE = 12'hFFF;
    localparam logic [11:0] DEC_EDGE = 12'h000;
`else
    localparam logic [11:0] INC_EDGE = 12'h000;
    localparam logic [11:0] DEC_EDGE = 12'hFFF;
`endif

    logic clk = 1'b1;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    addr_ctr_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    addr_ctr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step(input logic [5:0] ctl, input logic [11:0] din);
        {bus.CLR, bus.LD, bus.INC, bus.DEC, bus.PUSH, bus.POP} = ctl;
        bus.D_IN = din;
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        step(NOP, 12'h000);
        check("rst_dout",  bus.D_OUT, 12'h000);
        check("rst_level", bus.LEVEL, 0);
        check("rst_empty", bus.EMPTY, 1);
        check("rst_full",  bus.FULL,  0);
        check("rst_top",   bus.TOP,   12'h000);
        check("rst_err",   bus.ERR,   0);
        check("rst_bound", bus.BOUND, 0);
        reset = 1'b0;

        // Load and increment
        step(LD, 12'h0A5);
        check("ld_dout", bus.D_OUT, 12'h0A5);
        step(INC, 12'h000);
        check("inc1_bound", bus.BOUND, 0);
        step(INC, 12'h000);
        step(INC, 12'h000);
        check("inc3_dout",  bus.D_OUT, 12'h0A8);
        check("inc3_level", bus.LEVEL, 0);
        check("inc3_empty", bus.EMPTY, 1);
        check("inc3_err",   bus.ERR,   0);

        // Call/return pair
        step(LD, 12'h010);
        step(PUSH, 12'h200);
        check("push1_top",   bus.TOP,   12'h011);
        check("push1_dout",  bus.D_OUT, 12'h200);
        check("push1_level", bus.LEVEL, 1);
        step(PUSH, 12'h300);
        check("push2_dout",  bus.D_OUT, 12'h300);
        check("push2_top",   bus.TOP,   12'h201);
        step(POP, 12'h000);
        check("pop1_dout",  bus.D_OUT, 12'h201);
        check("pop1_top",   bus.TOP,   12'h011);
        step(POP, 12'h000);
        check("pop2_dout",  bus.D_OUT, 12'h011);
        check("pop2_empty", bus.EMPTY, 1);
        check("pop2_top",   bus.TOP,   12'h000);

        // Fill the stack and overflow it
        step(PUSH, 12'h100);
        step(PUSH, 12'h101);
        step(PUSH, 12'h102);
        check("fill3_full", bus.FULL, 0);
        step(PUSH, 12'h103);
        check("fill4_full",  bus.FULL,  1);
        check("fill4_level", bus.LEVEL, 4);
        step(PUSH, 12'h104);
        check("ovf_err",   bus.ERR,   1);
        check("ovf_level", bus.LEVEL, 4);
        check("ovf_dout",  bus.D_OUT, 12'h103);
        check("ovf_top",   bus.TOP,   12'h103);
        step(CLR, 12'h000);
        check("clr_dout",  bus.D_OUT, 12'h000);
        check("clr_err",   bus.ERR,   0);
        check("clr_level", bus.LEVEL, 4);

        // Drain back-to-back, then underflow
        step(POP, 12'h000);
        check("drain1_dout", bus.D_OUT, 12'h103);
        step(POP, 12'h000);
        check("drain2_dout", bus.D_OUT, 12'h102);
        step(POP, 12'h000);
        check("drain3_dout", bus.D_OUT, 12'h101);
        step(POP, 12'h000);
        check("drain4_dout",  bus.D_OUT, 12'h012);
        check("drain4_level", bus.LEVEL, 0);
        step(POP, 12'h000);
        check("udf_err",  bus.ERR,   1);
        check("udf_dout", bus.D_OUT, 12'h012);
        step(INC, 12'h000);
        check("err_sticky", bus.ERR, 1);
        step(CLR, 12'h000);

        // Address boundaries
        step(LD, 12'hFFF);
        step(INC, 12'h000);
        check("inc_edge_dout",  bus.D_OUT, INC_EDGE);
        check("inc_edge_bound", bus.BOUND, 1);
        step(NOP, 12'h000);
        check("bound_pulse", bus.BOUND, 0);
        step(LD, 12'h000);
        step(DEC, 12'h000);
        check("dec_edge_dout",  bus.D_OUT, DEC_EDGE);
        check("dec_edge_bound", bus.BOUND, 1);
        step(LD, 12'h005);
        step(DEC, 12'h000);
        check("dec_dout",  bus.D_OUT, 12'h004);
        check("dec_bound", bus.BOUND, 0);

        // POP wins over PUSH
        step(PUSH, 12'h050);
        check("pp_pre_level", bus.LEVEL, 1);
        step(POP | PUSH, 12'h070);
        check("pp_dout",  bus.D_OUT, 12'h005);
        check("pp_level", bus.LEVEL, 0);
        check("pp_err",   bus.ERR,   0);

        // Reset mid-sequence discards the stack
        step(PUSH, 12'h400);
        step(PUSH, 12'h500);
        check("pre_rst_level", bus.LEVEL, 2);
        reset = 1'b1;
        step(PUSH, 12'h600);
        reset = 1'b0;
        check("mid_rst_dout",  bus.D_OUT, 12'h000);
        check("mid_rst_level", bus.LEVEL, 0);
        check("mid_rst_top",   bus.TOP,   12'h000);
        check("mid_rst_err",   bus.ERR,   0);
        step(PUSH, 12'h0AB);
        check("post_rst_top",   bus.TOP,   12'h001);
        check("post_rst_level", bus.LEVEL, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
